fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the write port of one fifo instance between N_REQ producers.
- Each producer presents a word with a level request and receives a one-cycle ack per accepted word.
- Grants are held for bursts of up to MAX_BURST words, so a streaming producer keeps ownership while fairness is bounded.
- Sits directly in front of the fifo: drives wr/w_data and observes full.

Parameters:
N_REQ, 4, number of requesters (2..8)
D_WIDTH, 8, data width; must match the fifo D_WIDTH
MAX_BURST, 4, max words transferred per grant (1..16)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 at a posedge resets)
req  input  N_REQ  per-requester write request; held high with data stable until ack
req_data  input  N_REQ*D_WIDTH  packed data; requester i uses bits [i*D_WIDTH +: D_WIDTH]
fifo_full  input  1  fifo full status
ack  output  N_REQ  one-hot; ack[i]=1 means requester i's word is written this cycle
fifo_wr  output  1  fifo write strobe
fifo_w_data  output  D_WIDTH  fifo write data
owner  output  $clog2(N_REQ)  index of current grant holder, valid when busy
busy  output  1  high while in BURST state

Behaviour:
- Registered state: fsm (IDLE, BURST), owner, rr_ptr, burst_cnt ($clog2(MAX_BURST)+1 bits).
- Reset values: fsm=IDLE, owner=0, rr_ptr=0, burst_cnt=0, so busy=0, ack=0, fifo_wr=0.
- Reset mid-burst: the word in flight that cycle is still decoded combinationally. It may be written only if rst is high in that cycle. With rst low, fifo_wr=0 and ack=0 are forced.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Next cycle: owner=i, burst_cnt=0, fsm=BURST.
  - No transfer occurs in IDLE, giving 1 cycle arbitration latency from req rise to earliest ack.
- BURST (combinational outputs):
  - xfer = req[owner] & ~fifo_full
  - fifo_wr = xfer
  - ack[owner] = xfer; all other ack bits 0
  - fifo_w_data = req_data slice of owner, driven whenever busy; 0 in IDLE
- BURST transitions:
  - On xfer: burst_cnt increments. If burst_cnt==MAX_BURST-1, go to IDLE with rr_ptr=(owner+1) mod N_REQ.
  - req[owner]==0: the burst ends with no transfer that cycle. Go to IDLE with rr_ptr=(owner+1) mod N_REQ.
  - fifo_full==1 with req[owner]==1: stall. No ack, burst_cnt unchanged, ownership retained. Stall length is unbounded.
- Other requesters' req changes during BURST are ignored until the next IDLE.
- Modulo wrap: rr_ptr and owner wrap from N_REQ-1 to 0. N_REQ need not be a power of 2.
- Throughput: MAX_BURST words per MAX_BURST+1 cycles under continuous load.
- The fifo is never written while full: fifo_wr implies ~fifo_full.
- The block never issues fifo rd.

Optional Feature:
FIFO_ARB_PRIO0_EN
- Defined: requester 0 has strict priority at every IDLE arbitration. If req[0]=1 in IDLE, owner=0 regardless of rr_ptr. rr_ptr is still updated after each burst and used only when req[0]=0. MAX_BURST still bounds each burst.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then single requester: rst low 2 cycles, then req=4'b0100 with data 8'hA5 held. Expected: ack[2] on the 2nd cycle after req rises; fifo_wr=1, fifo_w_data=8'hA5; burst of 4 words, then 1 IDLE cycle, then regrant to 2.
- Fairness: req=4'b1111 continuously, rr_ptr=0. Expected owner sequence 0,1,2,3,0; each owner gets exactly 4 acks; acks never overlap.
- Full stall: owner=1 mid-burst after 2 words, fifo_full=1 for 5 cycles. Expected: no ack, fifo_wr=0, busy=1, owner=1; after full drops, exactly 2 more words are transferred, then rotation to 2.
- Early release and wrap: owner=3 drops req after 1 word, req=4'b0011. Expected: IDLE, then owner=0 (wrap from 3).
- Reset mid-burst: rst low while owner=2 has 2 words done. Expected: next cycle busy=0, ack=0, rr_ptr=0; the following arbitration with req=4'b0110 grants 1.
- FIFO_ARB_PRIO0_EN: req=4'b1001 continuously. Expected: owner is always 0 (4-word bursts with 1-cycle gaps), requester 3 is never acked; without the macro, owner alternates 0,3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for a shared fifo write port.
// Define FIFO_ARB_PRIO0_EN to give requester 0 strict priority at each arbitration.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    input  logic                       fifo_full,
    output logic [N_REQ-1:0]           ack,
    output logic                       fifo_wr,
    output logic [D_WIDTH-1:0]         fifo_w_data,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t        fsm;
    logic [OW-1:0] rr_ptr, pick, idx, nxt;
    logic [CW-1:0] burst_cnt;
    logic          req_own, xfer, last;
    int            s;

    assign busy    = fsm == BURST;
    assign req_own = req[owner];
    assign xfer    = busy & req_own & ~fifo_full & rst;
    assign last    = burst_cnt == CW'(MAX_BURST - 1);
    assign fifo_wr = xfer;
    assign ack     = xfer ? N_REQ'(1) << owner : '0;
    assign nxt     = owner == OW'(N_REQ - 1) ? '0 : owner + 1'b1;

    // scan downward so the requester closest to rr_ptr wins
    always_comb begin
        pick = '0;
        idx  = '0;
        s    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s   = int'(rr_ptr) + k;
            s   = s >= N_REQ ? s - N_REQ : s;
            idx = OW'(s);
            pick = req[idx] ? idx : pick;
        end
`ifdef FIFO_ARB_PRIO0_EN
        pick = req[0] ? '0 : pick;
`endif
    end

    always_comb begin
        fifo_w_data = '0;
        for (int i = 0; i < N_REQ; i++)
            fifo_w_data = (busy && owner == OW'(i)) ? req_data[i*D_WIDTH +: D_WIDTH] : fifo_w_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm       <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (fsm == IDLE) begin
            if (|req) begin
                fsm       <= BURST;
                owner     <= pick;
                burst_cnt <= '0;
            end
        end else begin
            if (xfer)
                burst_cnt <= burst_cnt + 1'b1;
            if (!req_own || (xfer && last)) begin
                fsm    <= IDLE;
                rr_ptr <= nxt;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven per-cycle vectors plus a priority/fairness sequence.
module tb_fifo_wr_arbiter;
    logic        clk = 0;
    logic        rst = 0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = 32'hD3A5B1C0;
    logic        fifo_full = 0;
    logic [3:0]  ack;
    logic        fifo_wr;
    logic [7:0]  fifo_w_data;
    logic [1:0]  owner;
    logic        busy;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic       f;
        logic [3:0] a;
        logic [7:0] d;
        logic       b;
        logic [1:0] o;
    } vec_t;

    vec_t tbl[$];

    fifo_wr_arbiter #(.N_REQ(4), .D_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
        .ack(ack), .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic r, input logic [3:0] rq, input logic f,
                       input logic [3:0] a, input logic [7:0] d, input logic b, input logic [1:0] o);
        vec_t v;
        v = '{r: r, rq: rq, f: f, a: a, d: d, b: b, o: o};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string n, input int row, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", n, row, act, exp);
        end
    endtask

    initial begin
        int ack0, ack3, own3, words;
        repeat (2) @(posedge clk);
`ifndef FIFO_ARB_PRIO0_EN
        add(1, 0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
        add(1, 1, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
        add(1, 1, 4'b0100, 0, 4'b0000, 8'h00, 0, 0);
        add(4, 1, 4'b0100, 0, 4'b0100, 8'hA5, 1, 2);
        add(1, 1, 4'b0100, 0, 4'b0000, 8'h00, 0, 2);
        add(1, 1, 4'b0100, 0, 4'b0100, 8'hA5, 1, 2);
        add(1, 1, 4'b0000, 0, 4'b0000, 8'hA5, 1, 2);
        add(1, 1, 4'b0000, 0, 4'b0000, 8'h00, 0, 2);
        add(1, 0, 4'b0000, 0, 4'b0000, 8'h00, 0, 2);
        add(1, 1, 4'b1111, 0, 4'b0000, 8'h00, 0, 0);
        add(4, 1, 4'b1111, 0, 4'b0001, 8'hC0, 1, 0);
        add(1, 1, 4'b1111, 0, 4'b0000, 8'h00, 0, 0);
        add(4, 1, 4'b1111, 0, 4'b0010, 8'hB1, 1, 1);
        add(1, 1, 4'b1111, 0, 4'b0000, 8'h00, 0, 1);
        add(4, 1, 4'b1111, 0, 4'b0100, 8'hA5, 1, 2);
        add(1, 1, 4'b1111, 0, 4'b0000, 8'h00, 0, 2);
        add(4, 1, 4'b1111, 0, 4'b1000, 8'hD3, 1, 3);
        add(1, 1, 4'b1111, 0, 4'b0000, 8'h00, 0, 3);
        add(4, 1, 4'b1111, 0, 4'b0001, 8'hC0, 1, 0);
        add(1, 1, 4'b1111, 0, 4'b0000, 8'h00, 0, 0);
        add(2, 1, 4'b1111, 0, 4'b0010, 8'hB1, 1, 1);
        add(5, 1, 4'b1111, 1, 4'b0000, 8'hB1, 1, 1);
        add(2, 1, 4'b1111, 0, 4'b0010, 8'hB1, 1, 1);
        add(1, 1, 4'b1111, 0, 4'b0000, 8'h00, 0, 1);
        add(1, 1, 4'b1111, 0, 4'b0100, 8'hA5, 1, 2);
        add(1, 1, 4'b1000, 0, 4'b0000, 8'hA5, 1, 2);
        add(1, 1, 4'b1000, 0, 4'b0000, 8'h00, 0, 2);
        add(1, 1, 4'b1000, 0, 4'b1000, 8'hD3, 1, 3);
        add(1, 1, 4'b0011, 0, 4'b0000, 8'hD3, 1, 3);
        add(1, 1, 4'b0011, 0, 4'b0000, 8'h00, 0, 3);
        add(1, 1, 4'b0011, 0, 4'b0001, 8'hC0, 1, 0);
        add(1, 1, 4'b0100, 0, 4'b0000, 8'hC0, 1, 0);
        add(1, 1, 4'b0100, 0, 4'b0000, 8'h00, 0, 0);
        add(2, 1, 4'b0100, 0, 4'b0100, 8'hA5, 1, 2);
        add(1, 0, 4'b0100, 0, 4'b0000, 8'hA5, 1, 2);
        add(1, 1, 4'b0110, 0, 4'b0000, 8'h00, 0, 0);
        add(1, 1, 4'b0110, 0, 4'b0010, 8'hB1, 1, 1);
        add(1, 1, 4'b0000, 0, 4'b0000, 8'hB1, 1, 1);
        add(1, 1, 4'b0000, 0, 4'b0000, 8'h00, 0, 1);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].r; req = tbl[i].rq; fifo_full = tbl[i].f;
            #1;
            chk("ack", i, {4'h0, ack}, {4'h0, tbl[i].a});
            chk("fifo_wr", i, {7'h0, fifo_wr}, {7'h0, |tbl[i].a});
            chk("fifo_w_data", i, fifo_w_data, tbl[i].d);
            chk("busy", i, {7'h0, busy}, {7'h0, tbl[i].b});
            chk("owner", i, {6'h0, owner}, {6'h0, tbl[i].o});
        end

        // requesters 0 and 3 compete continuously from a fresh reset
        @(negedge clk); rst = 0; req = 4'b0000; fifo_full = 0;
        @(negedge clk); rst = 1; req = 4'b1001;
        ack0 = 0; ack3 = 0; own3 = 0; words = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            ack0 += int'(ack[0]);
            ack3 += int'(ack[3]);
            words += int'(fifo_wr);
            own3 += int'(busy && owner == 2'd3);
            chk("ack_onehot", 100 + c, {7'h0, $countones(ack) > 1}, 8'h0);
            chk("wr_vs_ack", 100 + c, {7'h0, fifo_wr}, {7'h0, |ack});
            @(negedge clk);
        end
        chk("words_in_20", 200, 8'(words), 8'd16);
`ifdef FIFO_ARB_PRIO0_EN
        chk("ack0_count", 201, 8'(ack0), 8'd16);
        chk("ack3_count", 202, 8'(ack3), 8'd0);
        chk("owner3_cycles", 203, 8'(own3), 8'd0);
`else
        chk("ack0_count", 201, 8'(ack0), 8'd8);
        chk("ack3_count", 202, 8'(ack3), 8'd8);
        chk("owner3_cycles", 203, 8'(own3), 8'd8);
`endif
        req = 4'b0000;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
